// File: rtl/riscv_pkg.sv
// Shared core types for the integer register file: widths, address/word types and init FSM states.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register-file access bundle: two read ports, one write port, debug read and ready.
interface regfile_2r1w_if;
    import riscv_pkg::*;

    reg_addr_t a1;
    reg_addr_t a2;
    reg_addr_t a3;
    logic      we3;
    word_t     wd3;
    word_t     rd1;
    word_t     rd2;
    reg_addr_t dbg_a;
    word_t     dbg_rd;
    logic      ready;

    modport master (
        output a1, a2, a3, we3, wd3, dbg_a,
        input  rd1, rd2, dbg_rd, ready
    );

    modport slave (
        input  a1, a2, a3, we3, wd3, dbg_a,
        output rd1, rd2, dbg_rd, ready
    );

endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset sweep that zeroes x1..x(NREG-1) one per edge, then raises ready for good.
module regfile_init_seq
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    output logic      init_we,
    output reg_addr_t init_addr,
    output logic      ready
);

    localparam reg_addr_t LAST_ADDR = REG_AW'(NREG - 1);

    rf_state_t state, state_nxt;
    reg_addr_t init_ptr, init_ptr_nxt;
    logic      ready_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RF_INIT;
            init_ptr <= REG_AW'(1);
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
            ready    <= ready_nxt;
        end
    end

    // The edge that clears the last register also hands the file over to the core.
    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        ready_nxt    = ready;
        init_we      = 1'b0;
        case (state)
            RF_INIT: begin
                init_we      = 1'b1;
                init_ptr_nxt = init_ptr + REG_AW'(1);
                if (init_ptr == LAST_ADDR) begin
                    state_nxt = RF_RUN;
                    ready_nxt = 1'b1;
                end
            end
            RF_RUN: begin
                state_nxt = RF_RUN;
            end
            default: begin
                state_nxt = RF_INIT;
            end
        endcase
    end

    assign init_addr = init_ptr;

endmodule

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational reads, one edge write, x0 tied to zero, debug read.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto rd1/rd2.
module regfile_2r1w
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    regfile_2r1w_if.slave  rf
);

    word_t     mem [NREG];
    logic      init_we;
    reg_addr_t init_addr;
    logic      ready;
    logic      wr_en;

    regfile_init_seq u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    // Qualifying with ready && we3 first keeps an X address from reaching the decode.
    assign wr_en = rf.we3 && ready && (rf.a3 != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[rf.a3] <= rf.wd3;
        end else if (init_we) begin
            mem[init_addr] <= '0;
        end
    end

    always_comb begin
        rf.rd1    = '0;
        rf.rd2    = '0;
        rf.dbg_rd = '0;
        if (ready) begin
            if (rf.a1 != '0) rf.rd1 = mem[rf.a1];
            if (rf.a2 != '0) rf.rd2 = mem[rf.a2];
            if (rf.dbg_a != '0) rf.dbg_rd = mem[rf.dbg_a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rf.a3 == rf.a1)) rf.rd1 = rf.wd3;
            if (wr_en && (rf.a3 == rf.a2)) rf.rd2 = rf.wd3;
`endif
        end
    end

    assign rf.ready = ready;

endmodule
